seq_stage_controller: RTL and testbench

- Multi-cycle sequencer for the SEQ Y86-64 processor: steps Fetch, Decode, Execute, Memory, Writeback and PC-update in order, one stage enable per state.
- Owns the architectural PC register and the new-PC select (call/jXX/ret/default), plus the processor status (Stat) and halt logic.
- Sits above the stage blocks. It consumes icode/cnd/valC/valM/valP and error flags from them, and drives their enables plus the PC fed to Fetch.

---
 rtl/seq_stage_controller.sv | 147 ++++++++++++++
 tb/tb_seq_stage_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_stage_controller.sv
// SEQ Y86-64 multi-cycle sequencer: steps the stage enables,
// owns the architectural PC, Stat, halt and retired count.
module seq_stage_controller #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [PC_W-1:0]  valC,
  input  logic [PC_W-1:0]  valM,
  input  logic [PC_W-1:0]  valP,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
    S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       icode_q, icode_d;
  logic             mem_op;
  logic [PC_W-1:0]  new_pc;

  // icode is captured in FETCH so later decisions never see a live input
  always_comb begin
    mem_op = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8,
      4'h9, 4'hA, 4'hB: mem_op = 1'b1;
      default:          mem_op = 1'b0;
    endcase
  end

  always_comb begin
    new_pc = valP;
    case (icode_q)
      4'h8:    new_pc = valC;
      4'h7:    new_pc = cnd ? valC : valP;
      4'h9:    new_pc = valM;
      default: new_pc = valP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        icode_d = icode;
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        if (!mem_op) begin
          state_d = S_WRITEBACK;
        end else if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (mem_ready) begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d    = new_pc;
        cnt_d   = cnt_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
      icode_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
    end
  end

  assign pc          = pc_q;
  assign stat        = stat_q;
  assign instr_count = cnt_q;
  assign f_en        = (state_q == S_FETCH);
  assign d_en        = (state_q == S_DECODE);
  assign e_en        = (state_q == S_EXECUTE);
  assign m_en        = (state_q == S_MEMORY);
  assign w_en        = (state_q == S_WRITEBACK);
  assign pc_en       = (state_q == S_PCUPD);
  assign mem_req     = (state_q == S_MEMORY) && mem_op;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized bench for seq_stage_controller against a
// per-instruction cycle-trace model.
module tb_seq_stage_controller;

  logic        clk = 1'b0;
  logic        reset, start, cnd;
  logic [3:0]  icode;
  logic [63:0] valC, valM, valP;
  logic        instr_valid, imem_error, dmem_error, mem_ready;
  logic [63:0] pc;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, halted;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic [2:0]  m_stat;
  bit          m_halt;

  seq_stage_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .icode(icode), .cnd(cnd),
    .valC(valC), .valM(valM), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .mem_ready(mem_ready),
    .pc(pc), .f_en(f_en), .d_en(d_en), .e_en(e_en),
    .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
    .mem_req(mem_req), .stat(stat), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] en_vec();
    return {f_en, d_en, e_en, m_en, w_en, pc_en};
  endfunction

  function automatic bit is_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  task automatic chk_arch(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".cnt"}, 64'(instr_count), 64'(m_cnt));
    chk({tag, ".stat"}, 64'(stat), 64'(m_stat));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
  endtask

  // reset and leave the DUT in FETCH at a falling edge
  task automatic reset_and_start();
    reset = 1'b1; start = 1'b0;
    mem_ready = 1'b0; dmem_error = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_pc = '0; m_cnt = '0; m_stat = 3'd1; m_halt = 1'b0;
    chk("rst.en", 64'(en_vec()), 64'(0));
    chk("rst.req", 64'(mem_req), 64'(0));
    chk_arch("rst");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start.fetch", 64'(f_en), 64'(1));
  endtask

  task automatic run_instr(input logic [3:0] ic, input logic [63:0] vc,
                           input logic [63:0] vm, input logic [63:0] vp,
                           input bit c, input int wait_n,
                           input bit derr, input bit ierr, input bit ivld);
    logic [5:0] en_q[$];
    bit req_q[$], rdy_q[$], de_q[$];
    bit stop;
    icode = ic; valC = vc; valM = vm; valP = vp; cnd = c;
    imem_error = ierr; instr_valid = ivld;
    stop = 1'b0;
    en_q.push_back(6'b100000);
    req_q.push_back(0); rdy_q.push_back(0); de_q.push_back(0);
    if (ierr)       begin stop = 1; m_stat = 3'd3; end
    else if (!ivld) begin stop = 1; m_stat = 3'd4; end
    else if (ic == 0) begin stop = 1; m_stat = 3'd2; end
    if (!stop) begin
      en_q.push_back(6'b010000); en_q.push_back(6'b001000);
      repeat (2) begin
        req_q.push_back(0); rdy_q.push_back(0); de_q.push_back(0);
      end
      if (is_mem(ic)) begin
        for (int k = 0; k <= wait_n; k++) begin
          en_q.push_back(6'b000100);
          req_q.push_back(1);
          rdy_q.push_back(k == wait_n);
          de_q.push_back(derr && k == wait_n);
        end
        if (derr) begin stop = 1; m_stat = 3'd3; end
      end else begin
        en_q.push_back(6'b000100);
        req_q.push_back(0);
        rdy_q.push_back(1'($urandom));
        de_q.push_back(1'($urandom));
      end
    end
    if (!stop) begin
      en_q.push_back(6'b000010); en_q.push_back(6'b000001);
      repeat (2) begin
        req_q.push_back(0); rdy_q.push_back(0); de_q.push_back(0);
      end
    end
    foreach (en_q[i]) begin
      chk("trace.en", 64'(en_vec()), 64'(en_q[i]));
      chk("trace.req", 64'(mem_req), 64'(req_q[i]));
      mem_ready  = rdy_q[i];
      dmem_error = de_q[i];
      start      = 1'($urandom);
      @(negedge clk);
    end
    mem_ready = 1'b0; dmem_error = 1'b0; start = 1'b0;
    if (stop) begin
      m_halt = 1'b1;
      for (int k = 0; k < 20; k++) begin
        chk("halt.en", 64'(en_vec()), 64'(0));
        chk("halt.req", 64'(mem_req), 64'(0));
        start = 1'($urandom); mem_ready = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0; mem_ready = 1'b0;
      chk_arch("halt");
    end else begin
      if (ic == 4'h8 || (ic == 4'h7 && c)) m_pc = vc;
      else if (ic == 4'h9) m_pc = vm;
      else m_pc = vp;
      m_cnt = m_cnt + 1;
      chk("next.fetch", 64'(f_en), 64'(1));
      chk_arch("done");
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; icode = '0; cnd = 1'b0;
    valC = '0; valM = '0; valP = '0;
    instr_valid = 1'b1; imem_error = 1'b0;
    dmem_error = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    reset_and_start();
    run_instr(4'h3, 64'd10, 64'd20, 64'd30, 0, 0, 0, 0, 1);
    run_instr(4'h8, 64'd10, 64'd20, 64'd30, 0, 3, 0, 0, 1);
    run_instr(4'h9, 64'd10, 64'd20, 64'd30, 0, 3, 0, 0, 1);
    run_instr(4'h7, 64'd10, 64'd20, 64'd30, 0, 0, 0, 0, 1);
    run_instr(4'h7, 64'd10, 64'd20, 64'd30, 1, 0, 0, 0, 1);
    run_instr(4'h8, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd9, 0, 0, 0, 0, 1);

    for (int n = 0; n < 60; n++)
      run_instr(4'($urandom_range(1, 11)), r64(), r64(), r64(),
                1'($urandom), $urandom_range(0, 4), 0, 0, 1);

    run_instr(4'h5, r64(), r64(), r64(), 0, 0, 1, 0, 1);

    reset_and_start();
    run_instr(4'h0, r64(), r64(), r64(), 0, 0, 0, 0, 1);
    reset_and_start();
    run_instr(4'h3, r64(), r64(), r64(), 0, 0, 0, 0, 0);
    reset_and_start();
    run_instr(4'h0, r64(), r64(), r64(), 0, 0, 0, 1, 1);

    reset_and_start();
    run_instr(4'hA, r64(), r64(), r64(), 0, 1, 0, 0, 1);
    run_instr(4'hB, r64(), r64(), r64(), 0, 2, 1, 0, 1);

    // reset in the middle of a memory wait
    reset_and_start();
    run_instr(4'h6, 64'd0, 64'd0, 64'h40, 0, 0, 0, 0, 1);
    icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0;
    repeat (4) @(negedge clk);
    chk("midmem.req", 64'(mem_req), 64'(1));
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    m_pc = '0; m_cnt = '0; m_stat = 3'd1; m_halt = 1'b0;
    chk("midrst.en", 64'(en_vec()), 64'(0));
    chk("midrst.req", 64'(mem_req), 64'(0));
    chk_arch("midrst");
    @(negedge clk);
    chk("idle.hold", 64'(en_vec()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
